// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit slice per clock,
// inter-digit carry held in a register, result and flags committed on completion.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       M,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             sub_reg;
  logic             cin_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             v_reg;
  logic             z_reg;
  logic             n_reg;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] bx_dig;
  logic [DIGIT-1:0] s_dig;
  logic [DIGIT:0]   d_full;
  logic [WIDTH-1:0] word_next;
  logic             c_msb;
  logic             accept;
  logic             last;

  assign accept = start && (state_reg != RUN);
  assign last   = (cnt_reg == LAST);

  always_comb begin
    a_dig  = a_reg[int'(cnt_reg) * DIGIT +: DIGIT];
    bx_dig = b_reg[int'(cnt_reg) * DIGIT +: DIGIT] ^ {DIGIT{sub_reg}};
    d_full = {1'b0, a_dig} + {1'b0, bx_dig} + {{DIGIT{1'b0}}, cin_reg};
    s_dig  = d_full[DIGIT-1:0];
    // Carry into the digit's top bit recovered from the sum bit; only used on the last digit.
    c_msb  = a_dig[DIGIT-1] ^ bx_dig[DIGIT-1] ^ s_dig[DIGIT-1];
    word_next = acc_reg;
    word_next[int'(cnt_reg) * DIGIT +: DIGIT] = s_dig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sub_reg   <= 1'b0;
      cin_reg   <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      v_reg     <= 1'b0;
      z_reg     <= 1'b0;
      n_reg     <= 1'b0;
    end else if (accept) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      a_reg     <= A;
      b_reg     <= B;
      sub_reg   <= M[0];
      // ADC/SBC chain from the previous word's carry; plain SUB injects the +1 of ~B.
      cin_reg   <= M[1] ? carry_reg : M[0];
    end else if (state_reg == RUN) begin
      acc_reg <= word_next;
      cin_reg <= d_full[DIGIT];
      if (last) begin
        state_reg <= DONE;
        sum_reg   <= word_next;
        carry_reg <= d_full[DIGIT];
        v_reg     <= c_msb ^ d_full[DIGIT];
        z_reg     <= (word_next == '0);
        n_reg     <= word_next[WIDTH-1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else if (state_reg == DONE) begin
      state_reg <= IDLE;
    end
  end

  assign Sum   = sum_reg;
  assign Carry = carry_reg;
  assign V     = v_reg;
  assign Z     = z_reg;
  assign N     = n_reg;
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);

endmodule
